// File: rtl/pipe_seg_skid_reg_if.sv
// pipe_seg_skid_reg_if: upstream and downstream valid/ready beats of one pipeline segment
interface pipe_seg_skid_reg_if #(
    parameter int DATA_W  = 64,
    parameter int CTRL_W  = 16,
    parameter int PULSE_W = 2
);
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic [CTRL_W-1:0]  in_ctrl;
    logic [PULSE_W-1:0] in_pulse_req;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [CTRL_W-1:0]  out_ctrl;
    logic [PULSE_W-1:0] out_pulse;
    modport master (
        output in_valid, in_data, in_ctrl, in_pulse_req, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, out_pulse
    );
    modport slave (
        input  in_valid, in_data, in_ctrl, in_pulse_req, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, out_pulse
    );
endinterface

// File: rtl/pipe_seg_skid_reg.sv
// pipe_seg_skid_reg: registered pipeline segment with flush, first-presentation pulses and stall counter; PIPE_SEG_SKID_EN adds a skid entry and registered in_ready
module pipe_seg_skid_reg #(
    parameter int DATA_W  = 64,
    parameter int CTRL_W  = 16,
    parameter int PULSE_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    pipe_seg_skid_reg_if.slave  bus,
    output logic [15:0]         stall_cnt
);
`ifdef PIPE_SEG_SKID_EN
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
`else
    typedef enum logic [0:0] {EMPTY, FULL} state_t;
`endif
    state_t             state, state_nxt;
    logic               in_beat, out_beat, load_main;
    logic [DATA_W-1:0]  main_data, src_data;
    logic [CTRL_W-1:0]  main_ctrl, src_ctrl;
    logic [PULSE_W-1:0] pulse_q, src_pulse;
    assign in_beat       = bus.in_valid & bus.in_ready;
    assign out_beat      = bus.out_valid & bus.out_ready;
    assign bus.out_valid = state != EMPTY;
    assign bus.out_data  = main_data;
    assign bus.out_ctrl  = main_ctrl;
    assign bus.out_pulse = pulse_q;
`ifdef PIPE_SEG_SKID_EN
    logic               load_skid, ready_q;
    logic [DATA_W-1:0]  skid_data;
    logic [CTRL_W-1:0]  skid_ctrl;
    logic [PULSE_W-1:0] skid_pulse;
    assign src_data     = state == SKID ? skid_data : bus.in_data;
    assign src_ctrl     = state == SKID ? skid_ctrl : bus.in_ctrl;
    assign src_pulse    = state == SKID ? skid_pulse : bus.in_pulse_req;
    assign bus.in_ready = ready_q;
    // next state and register load enables; the main register reloads from skid when it drains
    always_comb begin
        state_nxt = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        if (flush_i) state_nxt = EMPTY;
        else case (state)
            EMPTY: begin
                load_main = in_beat;
                state_nxt = in_beat ? FULL : EMPTY;
            end
            FULL: begin
                load_main = in_beat & out_beat;
                load_skid = in_beat & ~out_beat;
                state_nxt = in_beat ? (out_beat ? FULL : SKID) : (out_beat ? EMPTY : FULL);
            end
            default: begin
                load_main = out_beat;
                state_nxt = out_beat ? FULL : SKID;
            end
        endcase
    end
    // skid entry captures the beat that arrives while the main register is stalled
    always_ff @(posedge clk)
        if (rst) begin
            skid_data  <= '0;
            skid_ctrl  <= '0;
            skid_pulse <= '0;
        end else if (load_skid) begin
            skid_data  <= bus.in_data;
            skid_ctrl  <= bus.in_ctrl;
            skid_pulse <= bus.in_pulse_req;
        end
    // in_ready is precomputed from the next state so upstream never sees out_ready combinationally
    always_ff @(posedge clk)
        ready_q <= rst | (state_nxt != SKID);
`else
    assign src_data     = bus.in_data;
    assign src_ctrl     = bus.in_ctrl;
    assign src_pulse    = bus.in_pulse_req;
    assign bus.in_ready = ~bus.out_valid | bus.out_ready;
    // single-entry next state; an input beat in FULL always coincides with an output beat
    always_comb begin
        load_main = in_beat & ~flush_i;
        state_nxt = flush_i ? EMPTY : in_beat ? FULL : out_beat ? EMPTY : state;
    end
`endif
    // state register
    always_ff @(posedge clk)
        state <= rst ? EMPTY : state_nxt;
    // main register; the pulse register is set only in the cycle a new entry is first presented
    always_ff @(posedge clk)
        if (rst || flush_i) begin
            main_data <= '0;
            main_ctrl <= '0;
            pulse_q   <= '0;
        end else begin
            pulse_q <= load_main ? src_pulse : '0;
            if (load_main) begin
                main_data <= src_data;
                main_ctrl <= src_ctrl;
            end
        end
    // saturating count of stalled output cycles, cleared only by reset
    always_ff @(posedge clk)
        if (rst) stall_cnt <= '0;
        else if (bus.out_valid & ~bus.out_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 16'd1;
endmodule
